// File: rtl/execute_stage_if.sv
// Bundle of ID-stage inputs, EX-stage forwarding controls and EX/MEM outputs for execute_stage.
// The master side drives decoded instructions; the slave side is the execute slice.
interface execute_stage_if;
    logic        hazard;
    logic        memToRegId;
    logic        regWriteId;
    logic        memWriteId;
    logic        memReadId;
    logic [3:0]  aluOpId;
    logic        aluSrcId;
    logic        regDstId;
    logic [31:0] immediateExtendedId;
    logic [4:0]  addressRsId;
    logic [4:0]  addressRtId;
    logic [4:0]  addressRdId;
    logic [31:0] dataRsId;
    logic [31:0] dataRtId;
    logic [5:0]  funcId;
    logic [1:0]  forwardingMux0Ex;
    logic [1:0]  forwardingMux1Ex;
    logic [31:0] regWriteDataWb;

    logic        memToRegMem;
    logic        regWriteMem;
    logic        memWriteMem;
    logic        memReadMem;
    logic [31:0] aluResultMem;
    logic [31:0] memWriteDataMem;
    logic [4:0]  regWriteRegisterMem;
    logic        aluResultZeroEx;
    logic [4:0]  addressRsEx;
    logic [4:0]  addressRtEx;

    modport master (
        output hazard, memToRegId, regWriteId, memWriteId, memReadId, aluOpId,
               aluSrcId, regDstId, immediateExtendedId, addressRsId, addressRtId,
               addressRdId, dataRsId, dataRtId, funcId, forwardingMux0Ex,
               forwardingMux1Ex, regWriteDataWb,
        input  memToRegMem, regWriteMem, memWriteMem, memReadMem, aluResultMem,
               memWriteDataMem, regWriteRegisterMem, aluResultZeroEx,
               addressRsEx, addressRtEx
    );

    modport slave (
        input  hazard, memToRegId, regWriteId, memWriteId, memReadId, aluOpId,
               aluSrcId, regDstId, immediateExtendedId, addressRsId, addressRtId,
               addressRdId, dataRsId, dataRtId, funcId, forwardingMux0Ex,
               forwardingMux1Ex, regWriteDataWb,
        output memToRegMem, regWriteMem, memWriteMem, memReadMem, aluResultMem,
               memWriteDataMem, regWriteRegisterMem, aluResultZeroEx,
               addressRsEx, addressRtEx
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute slice: ID/EX register, forwarding muxes + ALU, EX/MEM register.
// Define EX_FORWARDING_EN to enable the operand forwarding muxes.
module execute_stage (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);
    logic        ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read;
    logic        ex_alu_src, ex_reg_dst;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_imm, ex_rs_data, ex_rt_data;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_func;

    logic        mem_mem_to_reg, mem_reg_write, mem_mem_write, mem_mem_read;
    logic [31:0] mem_alu_result, mem_store_data;
    logic [4:0]  mem_dest;

    logic [31:0] fwd_rs, fwd_rt, op_b, alu_result;
    logic [4:0]  shamt;

    // A load-use stall turns the captured instruction into an all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || bus.hazard) begin
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= 4'd0;
            ex_imm        <= 32'd0;
            ex_rs_data    <= 32'd0;
            ex_rt_data    <= 32'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rd         <= 5'd0;
            ex_func       <= 6'd0;
        end else begin
            ex_mem_to_reg <= bus.memToRegId;
            ex_reg_write  <= bus.regWriteId;
            ex_mem_write  <= bus.memWriteId;
            ex_mem_read   <= bus.memReadId;
            ex_alu_src    <= bus.aluSrcId;
            ex_reg_dst    <= bus.regDstId;
            ex_alu_op     <= bus.aluOpId;
            ex_imm        <= bus.immediateExtendedId;
            ex_rs_data    <= bus.dataRsId;
            ex_rt_data    <= bus.dataRtId;
            ex_rs         <= bus.addressRsId;
            ex_rt         <= bus.addressRtId;
            ex_rd         <= bus.addressRdId;
            ex_func       <= bus.funcId;
        end
    end

`ifdef EX_FORWARDING_EN
    always_comb begin
        case (bus.forwardingMux0Ex)
            2'b01:   fwd_rs = bus.regWriteDataWb;
            2'b10:   fwd_rs = mem_alu_result;
            default: fwd_rs = ex_rs_data;
        endcase
        case (bus.forwardingMux1Ex)
            2'b01:   fwd_rt = bus.regWriteDataWb;
            2'b10:   fwd_rt = mem_alu_result;
            default: fwd_rt = ex_rt_data;
        endcase
    end
`else
    // Forwarding controls stay on the interface so instantiations match both builds.
    logic unused_forwarding;
    assign unused_forwarding = ^{bus.forwardingMux0Ex, bus.forwardingMux1Ex, bus.regWriteDataWb};

    always_comb begin
        fwd_rs = ex_rs_data;
        fwd_rt = ex_rt_data;
    end
`endif

    assign op_b  = ex_alu_src ? ex_imm : fwd_rt;
    assign shamt = ex_imm[10:6];

    // Shifts always act on the forwarded rt value, independent of aluSrc.
    always_comb begin
        alu_result = 32'd0;
        case (ex_alu_op)
            4'b0000: alu_result = fwd_rs + op_b;
            4'b0001: alu_result = fwd_rs - op_b;
            4'b0010: begin
                case (ex_func)
                    6'b100000, 6'b100001: alu_result = fwd_rs + op_b;
                    6'b100010, 6'b100011: alu_result = fwd_rs - op_b;
                    6'b100100: alu_result = fwd_rs & op_b;
                    6'b100101: alu_result = fwd_rs | op_b;
                    6'b100110: alu_result = fwd_rs ^ op_b;
                    6'b100111: alu_result = ~(fwd_rs | op_b);
                    6'b101010: alu_result = {31'd0, $signed(fwd_rs) < $signed(op_b)};
                    6'b101011: alu_result = {31'd0, fwd_rs < op_b};
                    6'b000000: alu_result = fwd_rt << shamt;
                    6'b000010: alu_result = fwd_rt >> shamt;
                    6'b000011: alu_result = $unsigned($signed(fwd_rt) >>> shamt);
                    default:   alu_result = 32'd0;
                endcase
            end
            4'b0011: alu_result = fwd_rs & op_b;
            4'b0100: alu_result = fwd_rs | op_b;
            4'b0101: alu_result = {31'd0, $signed(fwd_rs) < $signed(op_b)};
            4'b0110: alu_result = op_b << 16;
            4'b0111: alu_result = fwd_rs ^ op_b;
            default: alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_mem_to_reg <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_alu_result <= 32'd0;
            mem_store_data <= 32'd0;
            mem_dest       <= 5'd0;
        end else begin
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_reg_write  <= ex_reg_write;
            mem_mem_write  <= ex_mem_write;
            mem_mem_read   <= ex_mem_read;
            mem_alu_result <= alu_result;
            mem_store_data <= fwd_rt;
            mem_dest       <= ex_reg_dst ? ex_rd : ex_rt;
        end
    end

    assign bus.memToRegMem         = mem_mem_to_reg;
    assign bus.regWriteMem         = mem_reg_write;
    assign bus.memWriteMem         = mem_mem_write;
    assign bus.memReadMem          = mem_mem_read;
    assign bus.aluResultMem        = mem_alu_result;
    assign bus.memWriteDataMem     = mem_store_data;
    assign bus.regWriteRegisterMem = mem_dest;
    assign bus.aluResultZeroEx     = (alu_result == 32'd0);
    assign bus.addressRsEx         = ex_rs;
    assign bus.addressRtEx         = ex_rt;
endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized checks of execute_stage against an instruction-level reference model.
// Forwarding expectations follow EX_FORWARDING_EN the same way the design build does.
module tb_execute_stage;
    typedef struct packed {
        logic        memToReg, regWrite, memWrite, memRead;
        logic [3:0]  aluOp;
        logic        aluSrc, regDst;
        logic [31:0] imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsData, rtData;
        logic [5:0]  func;
    } instr_t;

    typedef struct packed {
        logic        memToReg, regWrite, memWrite, memRead;
        logic [31:0] aluResult, storeData;
        logic [4:0]  dest;
    } mem_t;

    localparam logic [5:0] FUNCS [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F, 6'h01, 6'h2C};

    logic   clk;
    logic   reset;
    int     compared = 0;
    int     mismatched = 0;
    instr_t exI = '0;
    mem_t   expMem = '0;
    logic   modelValid = 1'b0;

    execute_stage_if bus ();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] regData,
                                           input logic [31:0] wb, input logic [31:0] memRes);
`ifdef EX_FORWARDING_EN
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return memRes;
        return regData;
`else
        return regData ^ 32'(sel & 2'b00) ^ (wb & 32'd0) ^ (memRes & 32'd0);
`endif
    endfunction

    // Arithmetic-level definition of each operation; a is rs, rtv is the forwarded rt.
    function automatic logic [31:0] refAlu(input instr_t i, input logic [31:0] a, input logic [31:0] rtv);
        logic [31:0] b;
        int unsigned sh;
        longint sa, sb;
        b  = i.aluSrc ? i.imm : rtv;
        sh = i.imm[10:6];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (i.aluOp)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return (sa < sb) ? 32'd1 : 32'd0;
            4'd6: return {b[15:0], 16'd0};
            4'd7: return a ^ b;
            4'd2: begin
                case (i.func)
                    6'h20, 6'h21: return a + b;
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
                    6'h00: return 32'(longint'(rtv) * (64'd1 << sh));
                    6'h02: return 32'(longint'(rtv) / (64'd1 << sh));
                    6'h03: return (rtv >> sh) | (rtv[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] randData();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.memToReg = 1'($urandom);
        i.regWrite = 1'($urandom);
        i.memWrite = 1'($urandom);
        i.memRead  = 1'($urandom);
        i.aluOp    = 4'($urandom_range(0, 9));
        i.aluSrc   = 1'($urandom);
        i.regDst   = 1'($urandom);
        i.imm      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($signed(16'($urandom)));
        i.rs       = 5'($urandom);
        i.rt       = 5'($urandom);
        i.rd       = 5'($urandom);
        i.rsData   = randData();
        i.rtData   = randData();
        i.func     = FUNCS[$urandom_range(0, 15)];
        return i;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkMem();
        checkOutput("memToRegMem", 32'(bus.memToRegMem), 32'(expMem.memToReg));
        checkOutput("regWriteMem", 32'(bus.regWriteMem), 32'(expMem.regWrite));
        checkOutput("memWriteMem", 32'(bus.memWriteMem), 32'(expMem.memWrite));
        checkOutput("memReadMem", 32'(bus.memReadMem), 32'(expMem.memRead));
        checkOutput("aluResultMem", bus.aluResultMem, expMem.aluResult);
        checkOutput("memWriteDataMem", bus.memWriteDataMem, expMem.storeData);
        checkOutput("regWriteRegisterMem", 32'(bus.regWriteRegisterMem), 32'(expMem.dest));
        checkOutput("addressRsEx", 32'(bus.addressRsEx), 32'(exI.rs));
        checkOutput("addressRtEx", 32'(bus.addressRtEx), 32'(exI.rt));
    endtask

    // One clock: present an ID instruction plus EX forwarding controls, then advance the model.
    task automatic applyStimulus(input instr_t ins, input logic hz, input logic rst,
                                 input logic [1:0] f0, input logic [1:0] f1, input logic [31:0] wb);
        logic [31:0] a, rtv, res;
        mem_t nextMem;
        reset                   = rst;
        bus.hazard              = hz;
        bus.memToRegId          = ins.memToReg;
        bus.regWriteId          = ins.regWrite;
        bus.memWriteId          = ins.memWrite;
        bus.memReadId           = ins.memRead;
        bus.aluOpId             = ins.aluOp;
        bus.aluSrcId            = ins.aluSrc;
        bus.regDstId            = ins.regDst;
        bus.immediateExtendedId = ins.imm;
        bus.addressRsId         = ins.rs;
        bus.addressRtId         = ins.rt;
        bus.addressRdId         = ins.rd;
        bus.dataRsId            = ins.rsData;
        bus.dataRtId            = ins.rtData;
        bus.funcId              = ins.func;
        bus.forwardingMux0Ex    = f0;
        bus.forwardingMux1Ex    = f1;
        bus.regWriteDataWb      = wb;
        #1;
        a   = fwdVal(f0, exI.rsData, wb, expMem.aluResult);
        rtv = fwdVal(f1, exI.rtData, wb, expMem.aluResult);
        res = refAlu(exI, a, rtv);
        if (modelValid) checkOutput("aluResultZeroEx", 32'(bus.aluResultZeroEx), 32'(res == 32'd0));
        nextMem.memToReg  = exI.memToReg;
        nextMem.regWrite  = exI.regWrite;
        nextMem.memWrite  = exI.memWrite;
        nextMem.memRead   = exI.memRead;
        nextMem.aluResult = res;
        nextMem.storeData = rtv;
        nextMem.dest      = exI.regDst ? exI.rd : exI.rt;
        @(posedge clk);
        if (rst) begin
            exI        = '0;
            expMem     = '0;
            modelValid = 1'b1;
        end else begin
            expMem = nextMem;
            exI    = hz ? instr_t'('0) : ins;
        end
        #1;
        if (modelValid) checkMem();
    endtask

    initial begin
        instr_t ins;
        instr_t nop;
        instr_t i2;
        nop = '0;

        // Reset with a busy, nonzero instruction on the ID inputs.
        ins = randInstr();
        ins.rsData = 32'h1234_5678;
        ins.regWrite = 1'b1;
        applyStimulus(ins, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0);
        checkOutput("reset_aluResultMem", bus.aluResultMem, 32'd0);
        checkOutput("reset_regWriteMem", 32'(bus.regWriteMem), 32'd0);
        checkOutput("reset_zero", 32'(bus.aluResultZeroEx), 32'd1);

        ins = nop;
        ins.aluOp = 4'b0010; ins.func = 6'b100000; ins.rsData = 32'd5; ins.rtData = 32'd7;
        ins.regDst = 1'b1; ins.rd = 5'd3; ins.rt = 5'd9; ins.regWrite = 1'b1;
        applyStimulus(ins, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(nop, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("radd_result", bus.aluResultMem, 32'd12);
        checkOutput("radd_dest", 32'(bus.regWriteRegisterMem), 32'd3);
        checkOutput("radd_regwrite", 32'(bus.regWriteMem), 32'd1);

        ins = nop;
        ins.aluOp = 4'b0001; ins.aluSrc = 1'b1; ins.imm = 32'd9; ins.rsData = 32'd9;
        applyStimulus(ins, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("subi_zero_flag", 32'(bus.aluResultZeroEx), 32'd1);
        applyStimulus(nop, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("subi_result", bus.aluResultMem, 32'd0);

        ins = nop;
        ins.aluSrc = 1'b1; ins.imm = 32'd100;
        i2 = nop;
        i2.rsData = 32'd11; i2.rtData = 32'd22;
        applyStimulus(ins, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(i2, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(nop, 1'b0, 1'b0, 2'd2, 2'd1, 32'd50);
`ifdef EX_FORWARDING_EN
        checkOutput("fwd_result", bus.aluResultMem, 32'd150);
`else
        checkOutput("fwd_result", bus.aluResultMem, 32'd33);
`endif

        ins = nop;
        ins.memWrite = 1'b1; ins.regWrite = 1'b1; ins.aluSrc = 1'b1; ins.imm = 32'd8;
        applyStimulus(ins, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(nop, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("bubble_memwrite", 32'(bus.memWriteMem), 32'd0);
        checkOutput("bubble_regwrite", 32'(bus.regWriteMem), 32'd0);

        ins = nop;
        ins.aluSrc = 1'b1; ins.imm = 32'd4; ins.rsData = 32'h100; ins.rtData = 32'hDEAD; ins.memWrite = 1'b1;
        applyStimulus(ins, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(nop, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("sw_address", bus.aluResultMem, 32'h104);
        checkOutput("sw_data", bus.memWriteDataMem, 32'hDEAD);

        ins = nop;
        ins.aluOp = 4'b0010; ins.func = 6'b000011; ins.rtData = 32'h8000_0000; ins.imm = 32'd4 << 6;
        applyStimulus(ins, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        applyStimulus(nop, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
        checkOutput("sra_result", bus.aluResultMem, 32'hF800_0000);

        // Reset must win over a simultaneous hazard.
        applyStimulus(randInstr(), 1'b1, 1'b1, 2'd0, 2'd0, 32'd0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(randInstr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
                          2'($urandom), 2'($urandom), randData());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute slice of the 5-stage MIPS pipeline, containing three parts:
  - the ID/EX pipeline register;
  - the EX-stage ALU with forwarding operand muxes and destination-register select;
  - the EX/MEM pipeline register.
- Sits between instruction decode and data memory.
- Its registered ALU result feeds back as the MEM-stage forwarding source.

Parameters:
- None. Datapath is fixed at 32 bits and register addresses at 5 bits.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  synchronous, active-high; clears every register.
- hazard  in  1  load-use stall; turns the ID/EX capture into a bubble.
- memToRegId, regWriteId, memWriteId, memReadId  in  1 each  decoded control bits.
- aluOpId  in  4  ALU operation class.
- aluSrcId  in  1  1 = operand B is the immediate.
- regDstId  in  1  1 = destination is rd, 0 = rt.
- immediateExtendedId  in  32  sign-extended immediate.
- addressRsId, addressRtId, addressRdId  in  5 each  register addresses.
- dataRsId, dataRtId  in  32 each  register-file read data.
- funcId  in  6  R-type funct field.
- forwardingMux0Ex, forwardingMux1Ex  in  2 each  forwarding selects for operand A (rs) and operand B (rt).
- regWriteDataWb  in  32  WB-stage write-back value.
- memToRegMem, regWriteMem, memWriteMem, memReadMem  out  1 each  registered control bits.
- aluResultMem  out  32  registered ALU result.
- memWriteDataMem  out  32  registered store data.
- regWriteRegisterMem  out  5  registered destination register.
- aluResultZeroEx  out  1  combinational; 1 when the current EX ALU result is 0.
- addressRsEx, addressRtEx  out  5 each  ID/EX register outputs, for the forwarding unit.

Behaviour:
- Reset: when reset=1 at a clock edge, every ID/EX and EX/MEM field clears to 0. All outputs are then 0, except aluResultZeroEx=1 (0 ADD 0).
- ID/EX, hazard=0: captures all ID inputs each edge.
- ID/EX, hazard=1: captures a bubble; every ID/EX field loads 0 (no write, no memory access).
- EX/MEM is never stalled.
- Latency: ID inputs registered at edge N are evaluated during cycle N+1 and appear on the *Mem outputs after edge N+1. Reset has priority over hazard.
- Forwarding select, applied independently to operand A and operand B:
  - 00 = ID/EX register data;
  - 01 = regWriteDataWb;
  - 10 = aluResultMem;
  - 11 = treated as 00.
- Operand A = forwarded rs.
- Operand B = immediate if aluSrc=1, else forwarded rt.
- Store data = forwarded rt, taken before the aluSrc mux.
- Destination = regDst ? rd : rt.
- aluOp encoding:
  - 0000 ADD
  - 0001 SUB
  - 0010 R-type (operation taken from func)
  - 0011 AND
  - 0100 OR
  - 0101 SLT (signed)
  - 0110 LUI: B<<16
  - 0111 XOR
  - others: result 0
- R-type func encoding:
  - 100000/100001 ADD
  - 100010/100011 SUB
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 101010 SLT signed
  - 101011 SLTU
  - 000000 SLL: rt<<shamt
  - 000010 SRL
  - 000011 SRA (arithmetic)
  - others: result 0
- Shift operands: shamt = immediate[10:6]; the shifted value is always forwarded rt.
- Arithmetic: 32-bit wrap-around, no overflow trap. SLT/SLTU produce 32'd0 or 32'd1.
- aluResultZeroEx = (EX ALU result == 0). It is combinational and not registered.

Optional Feature:
- Macro EX_FORWARDING_EN.
- Defined: forwarding muxes operate as described above.
- Undefined: forwardingMux0Ex/1Ex are ignored and operands always come from the ID/EX register data. The ports remain present, so instantiations are unchanged.

Test Plan:
- Reset: hold reset=1 for 1 cycle with nonzero ID inputs. Expect all *Mem outputs 0 and aluResultZeroEx=1.
- R-type ADD:
  - Stimulus: aluOp=0010, func=100000, rs data 5, rt data 7, regDst=1, rd=3, regWrite=1, forwards 00.
  - Expect: two edges later aluResultMem=12, regWriteRegisterMem=3, regWriteMem=1.
- Immediate SUB to zero:
  - Stimulus: aluOp=0001, aluSrc=1, imm=9, rs data 9.
  - Expect: aluResultZeroEx=1 during the EX cycle, aluResultMem=0.
- Forwarding:
  - Stimulus: first instruction produces aluResultMem=100; next has forwardingMux0Ex=10, forwardingMux1Ex=01, regWriteDataWb=50, ADD.
  - Expect: aluResultMem=150 (undefined macro: rs+rt register data).
- Hazard bubble: apply hazard=1 with a store (memWrite=1). Expect memWriteMem=0 and regWriteMem=0 after 2 edges.
- Store/shift, SW:
  - Stimulus: aluOp=0000, aluSrc=1, imm=4, rs=0x100, rt=0xDEAD, memWrite=1.
  - Expect: aluResultMem=0x104, memWriteDataMem=0xDEAD.
- Store/shift, SRA:
  - Stimulus: rt=0x80000000, shamt=4.
  - Expect: result 0xF8000000.
